// File: rtl/adder_pkg.sv
// Shared definitions for the adder library: FSM state encodings and a
// ceiling-log2 helper used to size counters.
package adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder; shared building block for the adder
// family (serial, ripple, carry-select).
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop process
// WIDTH-bit operands LSB first under a start/busy/done handshake.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    // A one-bit counter is still needed when WIDTH=1.
    localparam int CNT_W = (WIDTH > 1) ? clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  sa_reg, sa_next;
    logic [WIDTH-1:0]  sb_reg, sb_next;
    logic [WIDTH-1:0]  sum_reg, sum_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              carry_reg, carry_next;
    logic              cout_reg, cout_next;
    logic              ovf_reg, ovf_next;

    logic              fa_s;
    logic              fa_c;
    logic [WIDTH:0]    sum_shift;

    fa_cell u_fa (
        .a    (sa_reg[0]),
        .b    (sb_reg[0]),
        .cin  (carry_reg),
        .s    (fa_s),
        .cout (fa_c)
    );

    // New bit enters at the MSB; after WIDTH shifts the LSB result sits in bit 0.
    assign sum_shift = {fa_s, sum_reg};

    always_comb begin
        state_next = state_reg;
        sa_next    = sa_reg;
        sb_next    = sb_reg;
        sum_next   = sum_reg;
        cnt_next   = cnt_reg;
        carry_next = carry_reg;
        cout_next  = cout_reg;
        ovf_next   = ovf_reg;

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_RUN;
                    sa_next    = a;
                    sb_next    = sub ? ~b : b;
                    carry_next = sub ? 1'b1 : cin;
                    cnt_next   = '0;
                    sum_next   = '0;
                    cout_next  = 1'b0;
                    ovf_next   = 1'b0;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_RUN: begin
                sum_next   = sum_shift[WIDTH:1];
                sa_next    = sa_reg >> 1;
                sb_next    = sb_reg >> 1;
                carry_next = fa_c;
                cnt_next   = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_LAST) begin
                    // carry_reg here is the carry into the MSB.
                    cout_next  = fa_c;
                    ovf_next   = fa_c ^ carry_reg;
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            sa_reg    <= '0;
            sb_reg    <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sa_reg    <= sa_next;
            sb_reg    <= sb_next;
            sum_reg   <= sum_next;
            cnt_reg   <= cnt_next;
            carry_reg <= carry_next;
            cout_reg  <= cout_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;
    assign busy = (state_reg == S_RUN);
    assign done = (state_reg == S_DONE);

endmodule
